// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC sequencer/accumulator stage.
package mac_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 18;
    localparam int DEF_LEN_W  = 4;

    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {DEF_ACC_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MAC   = 2'd2,
        DONE  = 2'd3
    } mac_state_e;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational unsigned saturating adder: acc + product, clamped to all ones.
module mac_sat_add #(
    parameter int ACC_W  = 18,
    parameter int PROD_W = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);

    logic [ACC_W:0] wide_s;

    // One extra bit of headroom exposes the carry-out that signals saturation
    always_comb begin
        wide_s = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
        if (wide_s[ACC_W]) begin
            sum = {ACC_W{1'b1}};
            sat = 1'b1;
        end else begin
            sum = wide_s[ACC_W-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Burst sequencer: loads LEN operand pairs into the A/B registers, multiplies
// and saturating-accumulates them, then pulses done with the final sum.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ld,
    input  logic [DATA_W-1:0] a_q,
    input  logic [DATA_W-1:0] b_q,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              busy,
    output logic              done
);

    localparam int PROD_W = 2 * DATA_W;

    mac_state_e        state_r;
    mac_state_e        state_s;
    logic [LEN_W-1:0]  remaining_r;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  sum_s;
    logic              ovf_r;
    logic              busy_r;
    logic              done_r;
    logic              sat_s;
    logic              in_ready_s;
    logic              ld_s;
    logic [PROD_W-1:0] product_s;

    assign product_s = PROD_W'(a_q) * PROD_W'(b_q);

    mac_sat_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_add (
        .acc     (acc_r),
        .product (product_s),
        .sum     (sum_s),
        .sat     (sat_s)
    );

    // Next-state decode; in_ready/ld are combinational so a pair loads in the FETCH cycle itself
    always_comb begin
        state_s    = state_r;
        in_ready_s = 1'b0;
        ld_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = (len == '0) ? DONE : FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                in_ready_s = 1'b1;
                ld_s       = in_valid;
                if (in_valid) begin
                    state_s = MAC;
                end else begin
                    state_s = FETCH;
                end
            end
            MAC: begin
                if (remaining_r == LEN_W'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = FETCH;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, burst counter, accumulator and registered status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            remaining_r <= '0;
            acc_r       <= '0;
            ovf_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == FETCH) || (state_s == MAC);
            done_r  <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        remaining_r <= len;
                        acc_r       <= '0;
                        ovf_r       <= 1'b0;
                    end
                end
                MAC: begin
                    remaining_r <= remaining_r - LEN_W'(1);
                    acc_r       <= sum_s;
                    ovf_r       <= ovf_r | sat_s;
                end
                default: begin
                    remaining_r <= remaining_r;
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign ld       = ld_s;
    assign acc_out  = acc_r;
    assign ovf      = ovf_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a cycle-level reference model of bursts.
module tb_mac_seq_ctrl;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 18;
    localparam int LEN_W  = 4;
    localparam longint ACC_LIMIT = (longint'(1) << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic              ld;
    logic [DATA_W-1:0] a_d, b_d, a_q, b_q;
    logic [ACC_W-1:0]  acc_out;
    logic              ovf, busy, done;

    int nchecks = 0;
    int nerrors = 0;
    int pa[16];
    int pb[16];

    always #5 clk = ~clk;

    mac_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .ld(ld),
        .a_q(a_q), .b_q(b_q), .acc_out(acc_out), .ovf(ovf),
        .busy(busy), .done(done)
    );

    // A and B operand registers sharing the controller's load enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (ld) begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    function automatic longint model_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(pa[i]) * longint'(pb[i]);
        return s;
    endfunction

    // Runs one burst of l pairs; the first fetch is stalled for 'stall' cycles.
    // start is additionally pulsed in cycles sc1/sc2 (0 = never).
    task automatic test_burst(input string name, input int l, input int stall_in,
                              input int sc1, input int sc2);
        int stall, exp_done_c, k, macs;
        logic exp_ld, exp_fetch, exp_ovf;
        longint s, exp_acc;
        stall = (l == 0) ? 0 : stall_in;
        exp_done_c = 2 * l + 1 + stall;
        start = 1'b1;
        len = LEN_W'(l);
        in_valid = 1'($urandom_range(0, 1));
        a_d = DATA_W'($urandom);
        b_d = DATA_W'($urandom);
        @(posedge clk); #1;
        for (int c = 1; c <= exp_done_c + 3; c++) begin
            exp_ld = 1'b0;
            k = 0;
            if (l > 0 && c >= 1 + stall && c < exp_done_c && ((c - 1 - stall) % 2 == 0)) begin
                exp_ld = 1'b1;
                k = (c - 1 - stall) / 2;
            end
            exp_fetch = exp_ld || (l > 0 && c <= stall);
            start = (c == sc1) || (c == sc2);
            len = LEN_W'($urandom);
            if (exp_ld) begin
                in_valid = 1'b1;
                a_d = DATA_W'(pa[k]);
                b_d = DATA_W'(pb[k]);
            end else begin
                in_valid = exp_fetch ? 1'b0 : 1'($urandom_range(0, 1));
                a_d = DATA_W'($urandom);
                b_d = DATA_W'($urandom);
            end
            #1;
            macs = (c >= 3 + stall) ? (c - 3 - stall) / 2 + 1 : 0;
            if (macs > l) macs = l;
            s = model_sum(macs);
            exp_acc = (s > ACC_LIMIT) ? ACC_LIMIT : s;
            exp_ovf = (s > ACC_LIMIT);
            nchecks += 6;
            if (ld !== exp_ld) begin
                nerrors++; $display("FAIL %s c%0d ld: got %b exp %b", name, c, ld, exp_ld);
            end
            if (in_ready !== exp_fetch) begin
                nerrors++; $display("FAIL %s c%0d in_ready: got %b exp %b", name, c, in_ready, exp_fetch);
            end
            if (busy !== (c < exp_done_c)) begin
                nerrors++; $display("FAIL %s c%0d busy: got %b exp %b", name, c, busy, (c < exp_done_c));
            end
            if (done !== (c == exp_done_c)) begin
                nerrors++; $display("FAIL %s c%0d done: got %b exp %b", name, c, done, (c == exp_done_c));
            end
            if (acc_out !== ACC_W'(exp_acc)) begin
                nerrors++; $display("FAIL %s c%0d acc_out: got %0d exp %0d", name, c, acc_out, exp_acc);
            end
            if (ovf !== exp_ovf) begin
                nerrors++; $display("FAIL %s c%0d ovf: got %b exp %b", name, c, ovf, exp_ovf);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; a_d = '0; b_d = '0;
        @(posedge clk); @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; len = LEN_W'(5);
        #1;
        nchecks += 6;
        if (acc_out !== '0) begin nerrors++; $display("FAIL reset acc_out: got %0d exp 0", acc_out); end
        if (ovf !== 1'b0) begin nerrors++; $display("FAIL reset ovf: got %b exp 0", ovf); end
        if (busy !== 1'b0) begin nerrors++; $display("FAIL reset busy: got %b exp 0", busy); end
        if (done !== 1'b0) begin nerrors++; $display("FAIL reset done: got %b exp 0", done); end
        if (in_ready !== 1'b0) begin nerrors++; $display("FAIL reset in_ready: got %b exp 0", in_ready); end
        if (ld !== 1'b0) begin nerrors++; $display("FAIL reset ld: got %b exp 0", ld); end
        start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        nchecks += 2;
        if (busy !== 1'b0) begin nerrors++; $display("FAIL idle busy: got %b exp 0", busy); end
        if (in_ready !== 1'b0) begin nerrors++; $display("FAIL idle in_ready: got %b exp 0", in_ready); end
    endtask

    task automatic test_basic();
        pa[0] = 2; pb[0] = 3; pa[1] = 4; pb[1] = 5; pa[2] = 10; pb[2] = 10;
        test_burst("basic", 3, 0, 0, 0);
        nchecks++;
        if (acc_out !== 18'd126) begin nerrors++; $display("FAIL basic final acc_out: got %0d exp 126", acc_out); end
    endtask

    task automatic test_empty();
        test_burst("empty", 0, 0, 0, 0);
        nchecks++;
        if (acc_out !== 18'd0) begin nerrors++; $display("FAIL empty acc_out: got %0d exp 0", acc_out); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin pa[i] = 255; pb[i] = 255; end
        test_burst("saturate", 5, 0, 0, 0);
        nchecks += 2;
        if (acc_out !== 18'd262143) begin nerrors++; $display("FAIL saturate acc_out: got %0d exp 262143", acc_out); end
        if (ovf !== 1'b1) begin nerrors++; $display("FAIL saturate ovf: got %b exp 1", ovf); end
        pa[0] = 1; pb[0] = 1;
        test_burst("after_sat", 1, 0, 0, 0);
        nchecks += 2;
        if (acc_out !== 18'd1) begin nerrors++; $display("FAIL after_sat acc_out: got %0d exp 1", acc_out); end
        if (ovf !== 1'b0) begin nerrors++; $display("FAIL after_sat ovf: got %b exp 0", ovf); end
    endtask

    task automatic test_backpressure();
        pa[0] = 7; pb[0] = 8; pa[1] = 9; pb[1] = 9;
        test_burst("backpressure", 2, 3, 0, 0);
        nchecks++;
        if (acc_out !== 18'd137) begin nerrors++; $display("FAIL backpressure acc_out: got %0d exp 137", acc_out); end
    endtask

    task automatic test_ignored_start();
        pa[0] = 12; pb[0] = 13; pa[1] = 200; pb[1] = 3;
        // cycle 2 is the first MAC, cycle 5 is DONE for len=2
        test_burst("ignored_start", 2, 0, 2, 5);
        nchecks++;
        if (acc_out !== 18'd756) begin nerrors++; $display("FAIL ignored_start acc_out: got %0d exp 756", acc_out); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin pa[i] = 50; pb[i] = 50; end
        start = 1'b1; len = LEN_W'(4); in_valid = 1'b1;
        a_d = DATA_W'(pa[0]); b_d = DATA_W'(pb[0]);
        @(posedge clk); #1;
        start = 1'b0;
        // cycles 1..3 run normally; cycle 4 is the second MAC
        for (int c = 1; c < 4; c++) begin @(posedge clk); #1; end
        nchecks++;
        if (acc_out !== 18'd2500) begin nerrors++; $display("FAIL reset_mid pre acc_out: got %0d exp 2500", acc_out); end
        reset_n = 1'b0;
        #1;
        nchecks += 4;
        if (acc_out !== '0) begin nerrors++; $display("FAIL reset_mid acc_out: got %0d exp 0", acc_out); end
        if (busy !== 1'b0) begin nerrors++; $display("FAIL reset_mid busy: got %b exp 0", busy); end
        if (done !== 1'b0) begin nerrors++; $display("FAIL reset_mid done: got %b exp 0", done); end
        if (in_ready !== 1'b0) begin nerrors++; $display("FAIL reset_mid in_ready: got %b exp 0", in_ready); end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            nchecks += 2;
            if (done !== 1'b0) begin nerrors++; $display("FAIL reset_mid post c%0d done: got %b exp 0", c, done); end
            if (busy !== 1'b0) begin nerrors++; $display("FAIL reset_mid post c%0d busy: got %b exp 0", c, busy); end
        end
        in_valid = 1'b0;
        pa[0] = 3; pb[0] = 4; pa[1] = 5; pb[1] = 6;
        test_burst("after_reset", 2, 0, 0, 0);
    endtask

    task automatic test_random();
        int l, st;
        bit big;
        for (int n = 0; n < 25; n++) begin
            l = $urandom_range(0, 15);
            st = $urandom_range(0, 3);
            big = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 16; i++) begin
                pa[i] = big ? $urandom_range(200, 255) : $urandom_range(0, 255);
                pb[i] = big ? $urandom_range(200, 255) : $urandom_range(0, 255);
            end
            test_burst("random", l, st, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_saturation();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer and accumulator stage directly downstream of the MAC's 8-bit A/B input registers.
- Accepts a burst of LEN operand pairs from an upstream valid/ready source.
- Drives the shared load enable of the A and B registers, then consumes their registered outputs.
- Multiplies each pair, accumulates with saturation, and reports the result with a one-cycle done pulse.

Parameters:
DATA_W, 8, operand width of a_q/b_q (must match the input register width)
ACC_W, 18, accumulator width (must be >= 2*DATA_W)
LEN_W, 4, width of the burst length field

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin burst; sampled only in IDLE
len  in  LEN_W  number of pairs in the burst, sampled with start; 0 = empty burst
in_valid  in  1  upstream holds a valid A/B pair on the register d inputs
in_ready  out  1  controller can take a pair
ld  out  1  load enable to both A and B input registers
a_q  in  DATA_W  registered A operand
b_q  in  DATA_W  registered B operand
acc_out  out  ACC_W  accumulated sum, unsigned
ovf  out  1  sticky saturation flag for the current burst
busy  out  1  burst in progress
done  out  1  one-cycle pulse when acc_out is final

Behaviour:
- Reset: asynchronous, active-low. State goes to IDLE; acc_out=0, ovf=0, busy=0, done=0, in_ready=0, ld=0, remaining count=0. Reset mid-burst aborts the burst with no done pulse.
- FSM states: IDLE, FETCH, MAC, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - On start=1: latch len into remaining, clear acc_out to 0 and ovf to 0 at that edge.
  - Next state is DONE if len==0, else FETCH.
- FETCH:
  - busy=1, in_ready=1.
  - ld = in_valid & in_ready (combinational, so no extra cycle).
  - If in_valid=1, the registers capture at this edge and the next state is MAC; otherwise stay in FETCH.
- MAC:
  - busy=1, in_ready=0, ld=0.
  - product = a_q*b_q, unsigned, 2*DATA_W bits, zero-extended to ACC_W+1 for the add.
  - If acc_out+product > 2^ACC_W-1: acc_out <= all ones and ovf <= 1. Otherwise acc_out <= the sum.
  - ovf stays set until the next accepted start.
  - remaining decrements. If remaining was 1, next state is DONE; else FETCH.
- DONE:
  - done=1 for exactly one cycle, busy=0. Next state is IDLE.
  - acc_out and ovf hold their values until the next accepted start.
- Throughput: 2 cycles per pair with in_valid held high.
- Latency: done is asserted in cycle 2*len+1 after the start edge, counting the first cycle after that edge as cycle 1.
- start outside IDLE is ignored, including in DONE.
- Once saturated, acc_out stays at all ones for the rest of the burst.
- in_valid outside FETCH is ignored and produces no ld.
- All outputs are registered except in_ready and ld, which decode from state and in_valid.

Decomposition:
- Shared package mac_pkg holds:
  - state enum (IDLE=2'd0, FETCH=2'd1, MAC=2'd2, DONE=2'd3)
  - default widths DATA_W/ACC_W/LEN_W
  - ACC_MAX constant
- Optional sub-module mac_sat_add: combinational saturating adder, inputs acc and product, outputs sum and sat.
- The FSM, counter and accumulator register stay in mac_seq_ctrl.
- The testbench instantiates two input-register instances fed by ld alongside the DUT.

Test Plan:
- Basic burst: len=3, pairs (2,3),(4,5),(10,10), in_valid held 1 → ld high in cycles 1,3,5; acc_out=126; ovf=0; done pulse in cycle 7; busy low after.
- Empty burst: len=0 → done in cycle 1, acc_out=0, ovf=0, no ld pulse.
- Saturation: len=5, all pairs (255,255) → acc_out=260100 after pair 4, then 262143 with ovf=1 after pair 5. A following burst with len=1 and pair (1,1) gives acc_out=1, ovf=0.
- Backpressure: len=2, in_valid low 3 cycles in FETCH then high → no ld while low; acc_out correct (e.g. (7,8),(9,9) → 137); done delayed by 3 cycles.
- Ignored start: start pulsed during MAC and DONE → no restart, burst result unchanged, exactly one done pulse.
- Reset mid-burst: reset_n low during the second MAC of len=4 → immediate acc_out=0, busy=0, done never pulses; a new start after release runs normally.
